// File: rtl/swervolf_input_debounce_if.sv
// ---------------------------------------------------------------------------
// swervolf_input_debounce_if
//   Groups the switch conditioner's data and interrupt signals so the board
//   toplevel connects them as one bundle. The clock and reset stay plain
//   ports on the conditioner.
//
//   Signals (names match the conditioner's port list):
//     i_sw        raw asynchronous switch levels        (board -> conditioner)
//     i_irq_mask  per-bit enable for interrupt setting  (board -> conditioner)
//     i_irq_clr   synchronous clear of o_irq            (board -> conditioner)
//     o_sw        debounced levels                      (conditioner -> board)
//     o_rise      one-cycle accepted 0->1 pulses        (conditioner -> board)
//     o_fall      one-cycle accepted 1->0 pulses        (conditioner -> board)
//     o_irq       sticky change interrupt               (conditioner -> board)
//
//   Modports:
//     master  the side that owns the switch pins and consumes the results
//     slave   the debounce block itself
// ---------------------------------------------------------------------------
interface swervolf_input_debounce_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] i_sw;
  logic [WIDTH-1:0] i_irq_mask;
  logic             i_irq_clr;
  logic [WIDTH-1:0] o_sw;
  logic [WIDTH-1:0] o_rise;
  logic [WIDTH-1:0] o_fall;
  logic             o_irq;

  modport master (
    output i_sw,
    output i_irq_mask,
    output i_irq_clr,
    input  o_sw,
    input  o_rise,
    input  o_fall,
    input  o_irq
  );

  modport slave (
    input  i_sw,
    input  i_irq_mask,
    input  i_irq_clr,
    output o_sw,
    output o_rise,
    output o_fall,
    output o_irq
  );

endinterface

// File: rtl/swervolf_input_debounce.sv
// ---------------------------------------------------------------------------
// swervolf_input_debounce
//   Input conditioner for the board slide switches, feeding i_gpio[31:16] of
//   swervolf_core. Each bit is synchronised with two flops, then debounced:
//   a shared free-running prescaler produces a tick every TICK_CYCLES clocks,
//   and a per-bit 4-bit counter requires a changed level to persist across
//   STABLE_TICKS ticks before it is accepted into o_sw. Accepted changes emit
//   registered one-cycle rise/fall pulses and can set a sticky interrupt.
//
//   Parameters:
//     WIDTH         number of independent input bits
//     TICK_CYCLES   clock cycles per debounce tick (>= 2)
//     STABLE_TICKS  ticks a changed level must persist (1..15)
//
//   Ports:
//     i_clk   core clock (clk_core)
//     i_rst   asynchronous, active-high reset; clears every register
//     bus     slave side of swervolf_input_debounce_if
//             (i_sw, i_irq_mask, i_irq_clr in; o_sw, o_rise, o_fall, o_irq out)
// ---------------------------------------------------------------------------
module swervolf_input_debounce #(
  parameter int WIDTH        = 16,
  parameter int TICK_CYCLES  = 25000,
  parameter int STABLE_TICKS = 10
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  swervolf_input_debounce_if.slave    bus
);

  // Prescaler width: enough bits to hold TICK_CYCLES-1.
  localparam int              PW          = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0]   TICK_LAST   = PW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0]   PRESC_ZERO  = PW'(0);
  localparam logic [PW-1:0]   PRESC_ONE   = PW'(1);
  localparam logic [3:0]      STABLE_LAST = 4'(STABLE_TICKS - 1);

  // Synchroniser stages; only sync1_r ever samples the raw pins.
  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;

  // Shared tick prescaler.
  logic [PW-1:0]    presc_r;
  logic             tick_s;

  // Per-bit stability counters and their next-state values.
  logic [3:0]       cnt_r     [WIDTH];
  logic [3:0]       cnt_nxt_s [WIDTH];

  // A bit is "pending" while its synchronised level differs from o_sw.
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] accept_s;

  // Registered outputs.
  logic [WIDTH-1:0] sw_r;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic             irq_r;
  logic             irq_set_s;

  assign tick_s = (presc_r == TICK_LAST);
  assign diff_s = sync2_r ^ sw_r;

  // The interrupt looks at the pulses already on the outputs, so it rises
  // one cycle after the pulse and a set in that cycle beats a clear.
  assign irq_set_s = |((rise_r | fall_r) & bus.i_irq_mask);

  // Two-flop synchroniser for the asynchronous switch pins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= bus.i_sw;
      sync2_r <= sync1_r;
    end
  end

  // Free-running tick prescaler, wraps after TICK_CYCLES-1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc_r <= PRESC_ZERO;
    end else if (tick_s) begin
      presc_r <= PRESC_ZERO;
    end else begin
      presc_r <= presc_r + PRESC_ONE;
    end
  end

  // Per-bit stability decision: any cycle where the level matches o_sw
  // restarts the count, so short glitches never accumulate.
  always_comb begin
    accept_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt_s[i] = 4'd0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (diff_s[i]) begin
        if (tick_s) begin
          if (cnt_r[i] == STABLE_LAST) begin
            accept_s[i]  = 1'b1;
            cnt_nxt_s[i] = 4'd0;
          end else begin
            cnt_nxt_s[i] = cnt_r[i] + 4'd1;
          end
        end else begin
          cnt_nxt_s[i] = cnt_r[i];
        end
      end else begin
        cnt_nxt_s[i] = 4'd0;
      end
    end
  end

  // Stability counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Debounced level and edge pulses. An accepted bit always differs from
  // o_sw, so accepting it is a toggle; the new value is the sync level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_r   <= '0;
      rise_r <= '0;
      fall_r <= '0;
    end else begin
      sw_r   <= sw_r ^ accept_s;
      rise_r <= accept_s & sync2_r;
      fall_r <= accept_s & ~sync2_r;
    end
  end

  // Sticky change interrupt with synchronous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= (irq_r & ~bus.i_irq_clr) | irq_set_s;
    end
  end

  assign bus.o_sw   = sw_r;
  assign bus.o_rise = rise_r;
  assign bus.o_fall = fall_r;
  assign bus.o_irq  = irq_r;

endmodule

// File: tb/tb_swervolf_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_swervolf_input_debounce
//   Directed and randomised stimulus for swervolf_input_debounce with
//   TICK_CYCLES=4 and STABLE_TICKS=3. The reference model tracks, per bit,
//   the edge at which the synchronised level started to differ from the
//   debounced level and counts the prescaler ticks since then arithmetically
//   (a tick happens on every edge number that is a multiple of TICK_CYCLES,
//   counting edges from reset release).
// ---------------------------------------------------------------------------
module tb_swervolf_input_debounce;

  localparam int W = 16;
  localparam int T = 4;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  swervolf_input_debounce_if #(.WIDTH(W)) bus_if ();

  swervolf_input_debounce #(
    .WIDTH        (W),
    .TICK_CYCLES  (T),
    .STABLE_TICKS (S)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [W-1:0] m_s1, m_s2, m_osw, m_rise, m_fall;
  logic         m_irq;
  int           n_edge;
  int           a_edge  [W];
  bit           a_valid [W];

  // Last observed DUT outputs.
  logic [W-1:0] obs_sw, obs_rise, obs_fall;
  logic         obs_irq;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_osw = '0; m_rise = '0; m_fall = '0;
    m_irq = 1'b0;
    n_edge = 0;
    for (int i = 0; i < W; i++) begin
      a_edge[i]  = 0;
      a_valid[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [W-1:0] sw, input logic [W-1:0] mask, input logic clr);
    logic [W-1:0] acc;
    logic [W-1:0] new_osw;
    logic [W-1:0] new_s2;
    logic         irq_next;
    n_edge++;
    irq_next = (m_irq & ~clr) | (|((m_rise | m_fall) & mask));
    acc = '0;
    for (int i = 0; i < W; i++) begin
      if (a_valid[i] && ((n_edge / T) - (a_edge[i] / T)) == S) acc[i] = 1'b1;
    end
    new_osw = m_osw ^ acc;
    m_rise  = acc & m_s2;
    m_fall  = acc & ~m_s2;
    new_s2  = m_s1;
    m_s1    = sw;
    m_s2    = new_s2;
    m_osw   = new_osw;
    m_irq   = irq_next;
    for (int i = 0; i < W; i++) begin
      if (acc[i] || (m_s2[i] == m_osw[i])) a_valid[i] = 1'b0;
      if ((m_s2[i] != m_osw[i]) && !a_valid[i]) begin
        a_edge[i]  = n_edge;
        a_valid[i] = 1'b1;
      end
    end
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge, compare all outputs shortly after it.
  task automatic cycle(input logic [W-1:0] sw, input logic [W-1:0] mask, input logic clr);
    @(negedge clk);
    bus_if.i_sw       = sw;
    bus_if.i_irq_mask = mask;
    bus_if.i_irq_clr  = clr;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(sw, mask, clr);
    #1;
    obs_sw   = bus_if.o_sw;
    obs_rise = bus_if.o_rise;
    obs_fall = bus_if.o_fall;
    obs_irq  = bus_if.o_irq;
    chk("o_sw",   obs_sw,   m_osw);
    chk("o_rise", obs_rise, m_rise);
    chk("o_fall", obs_fall, m_fall);
    chk("o_irq",  {15'd0, obs_irq}, {15'd0, m_irq});
  endtask

  // Run n cycles with constant inputs and summarise what the DUT did on bits.
  task automatic run(input int n, input logic [W-1:0] sw, input logic [W-1:0] mask,
                     input logic [W-1:0] bits, output int rises, output int falls,
                     output int full_rises, output int lat);
    logic [W-1:0] start;
    start      = bus_if.o_sw;
    rises      = 0;
    falls      = 0;
    full_rises = 0;
    lat        = -1;
    for (int j = 1; j <= n; j++) begin
      cycle(sw, mask, 1'b0);
      if ((obs_rise & bits) != '0)   rises++;
      if ((obs_fall & bits) != '0)   falls++;
      if ((obs_rise & bits) == bits) full_rises++;
      if (lat < 0 && ((obs_sw ^ start) & bits) != '0) lat = j - 1;
    end
  endtask

  int   r, f, fr, lat;
  logic [W-1:0] cur_sw;

  initial begin
    bus_if.i_sw       = 16'hFFFF;
    bus_if.i_irq_mask = 16'h0000;
    bus_if.i_irq_clr  = 1'b0;
    model_reset();

    // Reset held with all switches high.
    for (int k = 0; k < 4; k++) begin
      cycle(16'hFFFF, 16'hFFFF, 1'b0);
      chk("reset_o_sw", obs_sw, 16'h0000);
    end
    rst = 1'b0;
    run(6, 16'h0000, 16'hFFFF, 16'hFFFF, r, f, fr, lat);

    // Stable press of bit 3.
    run(20, 16'h0008, 16'hFFFF, 16'h0008, r, f, fr, lat);
    chk("press_rises", 16'(r), 16'd1);
    chk("press_lat_in_window", 16'((lat >= 10 && lat <= 13) ? 1 : 0), 16'd1);
    chk("press_o_sw", obs_sw, 16'h0008);
    chk("press_irq", {15'd0, obs_irq}, 16'd1);

    // Release with interrupts masked: fall pulse, interrupt untouched.
    run(20, 16'h0000, 16'h0000, 16'h0008, r, f, fr, lat);
    chk("release_falls", 16'(f), 16'd1);
    chk("release_irq_held", {15'd0, obs_irq}, 16'd1);
    cycle(16'h0000, 16'h0000, 1'b1);
    chk("irq_cleared", {15'd0, obs_irq}, 16'd0);

    // Re-press with a clear coinciding with the rise pulse: set wins.
    r = 0;
    for (int j = 0; j < 20; j++) begin
      cycle(16'h0008, 16'h0008, (m_rise != '0));
      if (obs_rise[3]) r++;
    end
    chk("repress_rises", 16'(r), 16'd1);
    chk("repress_irq_set_wins", {15'd0, obs_irq}, 16'd1);

    // Bounce on bit 0: too short to be accepted, then a clean hold.
    run(6, 16'h0009, 16'hFFFF, 16'h0001, r, f, fr, lat);
    chk("bounce_hi_rises", 16'(r), 16'd0);
    run(10, 16'h0008, 16'hFFFF, 16'h0001, r, f, fr, lat);
    chk("bounce_lo_pulses", 16'(r + f), 16'd0);
    chk("bounce_o_sw0", {15'd0, obs_sw[0]}, 16'd0);
    run(20, 16'h0009, 16'hFFFF, 16'h0001, r, f, fr, lat);
    chk("bounce_hold_rises", 16'(r), 16'd1);

    // All bits together.
    run(20, 16'h0000, 16'hFFFF, 16'hFFFF, r, f, fr, lat);
    run(20, 16'hFFFF, 16'hFFFF, 16'hFFFF, r, f, fr, lat);
    chk("all_full_rise_cycles", 16'(fr), 16'd1);
    chk("all_rise_cycles", 16'(r), 16'd1);
    chk("all_o_sw", obs_sw, 16'hFFFF);

    // Reset in the middle of a count on bit 0.
    run(20, 16'h0000, 16'hFFFF, 16'hFFFF, r, f, fr, lat);
    run(7, 16'h0001, 16'hFFFF, 16'h0001, r, f, fr, lat);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("midreset_o_sw", bus_if.o_sw, 16'h0000);
    cycle(16'h0001, 16'hFFFF, 1'b0);
    cycle(16'h0001, 16'hFFFF, 1'b0);
    rst = 1'b0;
    run(20, 16'h0001, 16'hFFFF, 16'h0001, r, f, fr, lat);
    chk("midreset_rises", 16'(r), 16'd1);
    chk("midreset_lat_in_window", 16'((lat >= 10 && lat <= 13) ? 1 : 0), 16'd1);

    // Randomised switching, masks and clears against the model.
    cur_sw = 16'h0001;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 4) == 0) cur_sw = cur_sw ^ (16'h0001 << $urandom_range(0, 15));
      cycle(cur_sw, 16'($urandom()), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/swervolf_input_debounce.md
Name: swervolf_input_debounce

Overview:
- Board-level input conditioner for the 16 slide switches. It sits between the raw switch pins and the i_gpio[31:16] input of swervolf_core.
- Synchronises each switch bit, then debounces it with a shared millisecond-scale tick prescaler and per-bit stability counters.
- Emits single-cycle rise/fall event pulses and a sticky, maskable change interrupt.
- Replaces the plain two-flop switch sampling in the board toplevel.

Parameters:
- WIDTH, 16, number of independent input bits.
- TICK_CYCLES, 25000, clock cycles per debounce tick (1 ms at 25 MHz). Must be >= 2.
- STABLE_TICKS, 10, consecutive ticks a changed level must persist before it is accepted. Range 1..15.

Ports:
- i_clk  input  1  core clock (clk_core).
- i_rst  input  1  reset; asynchronous, active-high.
- i_sw  input  WIDTH  raw asynchronous switch levels.
- i_irq_mask  input  WIDTH  per-bit enable for interrupt setting.
- i_irq_clr  input  1  synchronous clear of o_irq.
- o_sw  output  WIDTH  debounced levels.
- o_rise  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 change.
- o_fall  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 change.
- o_irq  output  1  sticky change interrupt.

Behaviour:
- Reset (async assert, release synchronous to i_clk): all registers and outputs go to 0. This covers o_sw, o_rise, o_fall, o_irq, the sync flops, the prescaler and every per-bit counter.
- Synchroniser: two flops per bit. sync = second stage. No other logic samples i_sw.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 and wraps to 0.
  - tick = 1 in the cycle the count equals TICK_CYCLES-1.
  - Free-running; never held or restarted except by reset.
- Per-bit counter cnt[i], 4 bits, all bits evaluated independently in parallel. diff = sync[i] != o_sw[i].
  - Any cycle with diff = 0: cnt <= 0. A glitch shorter than the window therefore restarts the count.
  - diff = 1 and tick = 0: hold cnt.
  - diff = 1, tick = 1, cnt < STABLE_TICKS-1: cnt <= cnt+1.
  - diff = 1, tick = 1, cnt == STABLE_TICKS-1: o_sw[i] <= sync[i], cnt <= 0, and the matching pulse is registered on the same edge. o_rise[i] fires if the new value is 1; o_fall[i] fires if it is 0.
- Pulses: o_rise/o_fall are registered and deasserted in the following cycle. A bit can never pulse on two consecutive cycles, because the next acceptance needs at least STABLE_TICKS further ticks.
- Latency, from the input edge sampled to o_sw changing: 2 + (STABLE_TICKS-1)*TICK_CYCLES + [0..TICK_CYCLES-1] cycles.
- Several bits may be accepted on the same cycle; their pulses are coincident.
- Interrupt:
  - o_irq <= (o_irq & ~i_irq_clr) | (|((o_rise|o_fall) & i_irq_mask)), evaluated on the pulse cycle.
  - Set wins over a simultaneous clear.
  - Masked bits still pulse o_rise/o_fall but never set o_irq.
- Reset mid-debounce: the count is discarded and o_sw returns to 0. A switch still held high after reset release is re-debounced from scratch and produces an o_rise pulse.

Test Plan:
Benches use TICK_CYCLES=4, STABLE_TICKS=3, giving 10..13 cycles latency.
- Reset: hold i_rst with i_sw=16'hFFFF -> o_sw=0, o_rise=0, o_fall=0, o_irq=0 throughout.
- Stable press: i_sw 0->16'h0008, mask=16'hFFFF -> o_sw=16'h0008 after 10..13 cycles; o_rise=16'h0008 for exactly 1 cycle; o_irq=1 from the next cycle and held.
- Bounce: bit 0 high for 6 cycles, then low -> o_sw, o_rise and o_fall stay 0. Then hold high for 20 cycles -> exactly one rise pulse.
- Release plus interrupt: with o_sw=16'h0008, set i_sw=0 and mask=0 -> o_fall=16'h0008 for 1 cycle and o_irq unchanged. Pulse i_irq_clr -> o_irq=0 next cycle. Re-press bit 3 with mask bit 3 set and i_irq_clr asserted on the rise cycle -> o_irq=1.
- Simultaneous bits: i_sw 0->16'hFFFF -> all 16 bits accepted on the same cycle, o_rise=16'hFFFF for 1 cycle.
- Reset mid-count: i_sw=16'h0001 held, assert i_rst at cycle 7 -> o_sw=0 immediately. Release -> o_sw=16'h0001 10..13 cycles after release + 2, with one rise pulse.
